// File: rtl/assertion_result_collector_if.sv
// Report channel between the collector and whoever reads its statistics snapshots.
// The master side is the collector; the slave side issues requests and accepts reports.
interface assertion_result_collector_if #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) ();
  logic             report_req;
  logic             report_ready;
  logic             report_valid;
  logic [CNT_W-1:0] rpt_pass_cnt;
  logic [CNT_W-1:0] rpt_fail_cnt;
  logic [CNT_W-1:0] rpt_active_cnt;
  logic [TS_W-1:0]  rpt_first_fail_ts;
  logic [1:0]       rpt_state;

  modport master (
    input  report_req, report_ready,
    output report_valid, rpt_pass_cnt, rpt_fail_cnt, rpt_active_cnt,
           rpt_first_fail_ts, rpt_state
  );

  modport slave (
    output report_req, report_ready,
    input  report_valid, rpt_pass_cnt, rpt_fail_cnt, rpt_active_cnt,
           rpt_first_fail_ts, rpt_state
  );
endinterface

// File: rtl/assertion_result_collector.sv
// Collects pass/fail/activity statistics from an assertion checker and a verdict,
// and hands out an atomic snapshot of them over a valid/ready report channel.
module assertion_result_collector #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic assertion_pass,
  input  logic assertion_fail,
  input  logic assertion_active,
  input  logic clear,
  assertion_result_collector_if.master rpt,
  output logic [1:0] verdict,
  output logic       err_conflict
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    COVERED = 2'd2,
    FAILED  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [TS_W-1:0]  TS_ONE  = 1;
  localparam logic [TS_W-1:0]  TS_NONE = '1;

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] active_cnt_q, active_cnt_d;
  logic [TS_W-1:0]  ff_ts_q, ff_ts_d;
  logic [TS_W-1:0]  ts_q;
  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             load_snap;

  logic [CNT_W-1:0] snap_pass_q, snap_fail_q, snap_active_q;
  logic [TS_W-1:0]  snap_ff_q;
  logic [1:0]       snap_state_q;

  // Statistics next-state; a conflicting pass is dropped in favour of the fail.
  always_comb begin
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    active_cnt_d = active_cnt_q;
    ff_ts_d      = ff_ts_q;
    state_d      = state_q;
    err_d        = err_q;
    if (clear) begin
      pass_cnt_d   = '0;
      fail_cnt_d   = '0;
      active_cnt_d = '0;
      ff_ts_d      = TS_NONE;
      state_d      = IDLE;
      err_d        = 1'b0;
    end else begin
      if (assertion_fail) begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
        if (fail_cnt_q == '0) ff_ts_d = ts_q;
        state_d = FAILED;
      end else if (assertion_pass) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
        if (state_q == IDLE || state_q == ACTIVE) state_d = COVERED;
      end else if (assertion_active && state_q == IDLE) begin
        state_d = ACTIVE;
      end
      if (assertion_active && active_cnt_q != CNT_MAX) active_cnt_d = active_cnt_q + CNT_ONE;
      if (assertion_pass && assertion_fail) err_d = 1'b1;
    end
  end

  // Requests are only taken while no report is outstanding; they are never queued.
  always_comb begin
    valid_d   = valid_q;
    load_snap = 1'b0;
    if (!valid_q && rpt.report_req) begin
      valid_d   = 1'b1;
      load_snap = 1'b1;
    end else if (valid_q && rpt.report_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      active_cnt_q  <= '0;
      ff_ts_q       <= TS_NONE;
      ts_q          <= '0;
      state_q       <= IDLE;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      snap_pass_q   <= '0;
      snap_fail_q   <= '0;
      snap_active_q <= '0;
      snap_ff_q     <= TS_NONE;
      snap_state_q  <= 2'd0;
    end else begin
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      active_cnt_q <= active_cnt_d;
      ff_ts_q      <= ff_ts_d;
      ts_q         <= ts_q + TS_ONE;
      state_q      <= state_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      if (load_snap) begin
        snap_pass_q   <= pass_cnt_d;
        snap_fail_q   <= fail_cnt_d;
        snap_active_q <= active_cnt_d;
        snap_ff_q     <= ff_ts_d;
        snap_state_q  <= state_d;
      end
    end
  end

  assign verdict               = state_q;
  assign err_conflict          = err_q;
  assign rpt.report_valid      = valid_q;
  assign rpt.rpt_pass_cnt      = snap_pass_q;
  assign rpt.rpt_fail_cnt      = snap_fail_q;
  assign rpt.rpt_active_cnt    = snap_active_q;
  assign rpt.rpt_first_fail_ts = snap_ff_q;
  assign rpt.rpt_state         = snap_state_q;

endmodule

// File: tb/tb_assertion_result_collector.sv
// Scoreboard bench for assertion_result_collector: a statistics model predicts live
// status and report snapshots, and a monitor compares them as the DUT presents them.
module tb_assertion_result_collector;

  localparam int CNT_W   = 4;
  localparam int TS_W    = 32;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  localparam int V_IDLE    = 0;
  localparam int V_ACTIVE  = 1;
  localparam int V_COVERED = 2;
  localparam int V_FAILED  = 3;

  logic clk = 1'b0;
  logic rst;
  logic assertion_pass, assertion_fail, assertion_active, clear;
  logic [1:0] verdict;
  logic err_conflict;

  assertion_result_collector_if #(.CNT_W(CNT_W), .TS_W(TS_W)) bus ();

  assertion_result_collector #(.CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .assertion_pass   (assertion_pass),
    .assertion_fail   (assertion_fail),
    .assertion_active (assertion_active),
    .clear            (clear),
    .rpt              (bus),
    .verdict          (verdict),
    .err_conflict     (err_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          passCnt;
    int          failCnt;
    int          activeCnt;
    logic [31:0] firstFail;
    int          state;
  } snap_t;

  typedef struct {
    int verdict;
    bit err;
    bit valid;
  } live_t;

  snap_t rptQ[$];
  live_t liveQ[$];

  int nChecks = 0;
  int nPassed = 0;

  // Reference model state, describing the DUT as seen after the next rising edge.
  int          mPass, mFail, mActive, mVerdict;
  bit          mFfSeen, mErr, mPending;
  logic [31:0] mFf, mTs;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    else nPassed++;
  endtask

  function automatic int satInc(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  task automatic applyStimulus(input bit r, input bit p, input bit f, input bit a,
                               input bit c, input bit q, input bit rd);
    snap_t s;
    live_t l;
    @(negedge clk);
    rst = r; assertion_pass = p; assertion_fail = f; assertion_active = a;
    clear = c; bus.report_req = q; bus.report_ready = rd;
    if (r) begin
      mPass = 0; mFail = 0; mActive = 0; mVerdict = V_IDLE;
      mFfSeen = 0; mFf = '1; mErr = 0; mPending = 0; mTs = 0;
    end else begin
      if (c) begin
        mPass = 0; mFail = 0; mActive = 0; mVerdict = V_IDLE;
        mFfSeen = 0; mFf = '1; mErr = 0;
      end else begin
        if (f) begin
          mFail = satInc(mFail);
          if (!mFfSeen) begin mFfSeen = 1; mFf = mTs; end
          mVerdict = V_FAILED;
        end else if (p) begin
          mPass = satInc(mPass);
          if (mVerdict == V_IDLE || mVerdict == V_ACTIVE) mVerdict = V_COVERED;
        end else if (a && mVerdict == V_IDLE) begin
          mVerdict = V_ACTIVE;
        end
        if (a) mActive = satInc(mActive);
        if (p && f) mErr = 1;
      end
      mTs = mTs + 1;
      if (!mPending && q) begin
        s.passCnt = mPass; s.failCnt = mFail; s.activeCnt = mActive;
        s.firstFail = mFf; s.state = mVerdict;
        rptQ.push_back(s);
        mPending = 1;
      end else if (mPending && rd) begin
        mPending = 0;
      end
    end
    l.verdict = mVerdict; l.err = mErr; l.valid = mPending;
    liveQ.push_back(l);
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, rd);
  endtask

  // Monitor: live status every cycle, snapshot popped when a report is first presented.
  initial begin
    live_t l;
    snap_t cur;
    bit seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (liveQ.size() > 0) begin
        l = liveQ.pop_front();
        checkOutput("verdict", 64'(verdict), 64'(l.verdict));
        checkOutput("err_conflict", 64'(err_conflict), 64'(l.err));
        checkOutput("report_valid", 64'(bus.report_valid), 64'(l.valid));
      end
      if (bus.report_valid) begin
        if (!seen) begin
          if (rptQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL rpt_unexpected: got report_valid=1 expected no report");
          end else begin
            cur = rptQ.pop_front();
          end
          seen = 1;
        end
        checkOutput("rpt_pass_cnt", 64'(bus.rpt_pass_cnt), 64'(cur.passCnt));
        checkOutput("rpt_fail_cnt", 64'(bus.rpt_fail_cnt), 64'(cur.failCnt));
        checkOutput("rpt_active_cnt", 64'(bus.rpt_active_cnt), 64'(cur.activeCnt));
        checkOutput("rpt_first_fail_ts", 64'(bus.rpt_first_fail_ts), 64'(cur.firstFail));
        checkOutput("rpt_state", 64'(bus.rpt_state), 64'(cur.state));
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    rst = 1; assertion_pass = 0; assertion_fail = 0; assertion_active = 0;
    clear = 0; bus.report_req = 0; bus.report_ready = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    checkOutput("reset_rpt_pass", 64'(bus.rpt_pass_cnt), 64'd0);
    checkOutput("reset_rpt_fail", 64'(bus.rpt_fail_cnt), 64'd0);
    checkOutput("reset_rpt_active", 64'(bus.rpt_active_cnt), 64'd0);
    checkOutput("reset_rpt_ff", 64'(bus.rpt_first_fail_ts), 64'hFFFF_FFFF);
    checkOutput("reset_rpt_state", 64'(bus.rpt_state), 64'd0);

    // Three separated passes then a report.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      idle(1, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle(3, 1);

    // Two fails, a later pass, then a report.
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    idle(9, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle(3, 1);

    // Conflict, sticky error, then clear with a report in the same cycle.
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 1);
    idle(2, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    idle(3, 1);

    // Active held long enough to saturate the counter.
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle(3, 1);

    // Held report while passes continue; a second request is ignored.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, (i == 2), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle(3, 1);

    // Clear and fail together; the fail is dropped.
    applyStimulus(0, 0, 1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle(2, 1);
    applyStimulus(0, 0, 1, 0, 0, 1, 1);
    idle(3, 1);

    // Reset while a report is pending.
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(2, 1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 999) < 3,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 40);
    end

    idle(6, 1);
    @(posedge clk);
    #2;
    checkOutput("reports_outstanding", 64'(rptQ.size()), 64'd0);
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
